// File: rtl/if_id_buf_pkg.sv
// Shared fetch/decode definitions: bubble instruction and fetch-packet layout.
// No logic; constants and types only.
// Decode reuses NOP_INST when it inserts bubbles.
package if_id_buf_pkg;

    localparam int PC_W_DEF   = 64;
    localparam int INST_W_DEF = 32;
    localparam int FETCH_W    = PC_W_DEF + INST_W_DEF;

    // addi x0,x0,0
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [PC_W_DEF-1:0]   pc;
        logic [INST_W_DEF-1:0] inst;
    } fetch_pkt_t;

endpackage

// File: rtl/if_id_fifo_mem.sv
// Storage array for the IF/ID buffer: one write port, one asynchronous read port.
// Write lands on the clock edge; read data follows raddr combinationally.
// No flow control here; the owner guarantees writes only into free slots.
module if_id_fifo_mem
    import if_id_buf_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = FETCH_W
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);

    logic [W-1:0] mem [DEPTH];

    // Data slots carry no reset; validity is tracked by the owner's count.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_buf.sv
// IF/ID decoupling FIFO: holds fetched {pc, inst} pairs until decode takes them; flush kills all.
// Latency: enqueue at edge N is visible on out_* after edge N; no same-cycle bypass.
// Backpressure: in_ready = not full (independent of out_ready); out_valid masked by flush.
module if_id_buf #(
    parameter int                DEPTH    = 2,
    parameter int                PC_W     = 64,
    parameter int                INST_W   = 32,
    parameter logic [INST_W-1:0] NOP_INST = INST_W'(if_id_buf_pkg::NOP_INST)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [PC_W-1:0]          in_pc,
    input  logic [INST_W-1:0]        in_inst,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [PC_W-1:0]          out_pc,
    output logic [INST_W-1:0]        out_inst,
    input  logic                     out_ready,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count
);
    import if_id_buf_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int W  = PC_W + INST_W;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          enq;
    logic          deq;
    logic          not_empty;
    logic [W-1:0]  rd_dat;

    assign not_empty = (count != '0);
    assign in_ready  = (count != CW'(DEPTH));
    // Flush masks the head combinationally so decode never takes a stale instruction.
    assign out_valid = not_empty & ~flush;
    assign enq       = in_valid & in_ready & ~flush;
    assign deq       = out_valid & out_ready;

    if_id_fifo_mem #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_mem (
        .clk   (clk),
        .we    (enq),
        .waddr (wr_ptr),
        .wdata ({in_pc, in_inst}),
        .raddr (rd_ptr),
        .rdata (rd_dat)
    );

    assign out_pc   = not_empty ? rd_dat[W-1:INST_W]   : '0;
    assign out_inst = not_empty ? rd_dat[INST_W-1:0]   : NOP_INST;

    // Pointer/occupancy update: flush beats everything, then enq/deq combinations.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (deq) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (enq && !deq) begin
                count <= count + 1'b1;
            end else if (deq && !enq) begin
                count <= count - 1'b1;
            end
        end
    end

    // Occupancy must stay in 0..DEPTH: no push into a full buffer, no pop from an empty one.
    always @(posedge clk) begin
        if (rst) begin
            assert (count <= CW'(DEPTH));
            assert (!(enq && !deq && count == CW'(DEPTH)));
            assert (!(deq && !enq && count == '0));
        end
    end

endmodule

// File: doc/if_id_buf.md
Name: if_id_buf

Overview:
- Decoupling buffer between the instruction-fetch stage (PC register, icache, pre-decode) and the decode stage.
- Captures each fetched {pc, inst} pair when fetch signals an instruction update.
- Holds the pair until decode accepts it.
- Discards all buffered instructions on a control-flow redirect.
- Lets fetch run ahead by up to DEPTH instructions while decode or memory stalls.

Parameters:
- DEPTH, 2: number of buffered instruction slots; power of two, at least 2.
- PC_W, 64: program-counter width.
- INST_W, 32: instruction width.
- NOP_INST, 32'h00000013: value driven on out_inst when the buffer is empty (addi x0,x0,0).

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  fetch has a valid instruction this cycle (driven from inst_update).
- in_pc  in  PC_W  PC of the fetched instruction.
- in_inst  in  INST_W  fetched instruction word.
- in_ready  out  1  buffer can accept an entry this cycle.
- out_valid  out  1  head entry valid for decode.
- out_pc  out  PC_W  PC of head entry.
- out_inst  out  INST_W  instruction of head entry.
- out_ready  in  1  decode consumes head this cycle (driven from id_reg_finish).
- flush  in  1  redirect (taken jump/branch or exception); kill all entries.
- count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset:
  - Asserting rst (low) immediately clears wr_ptr, rd_ptr and count to 0, independent of clk.
  - Outputs during and after reset: out_valid=0, in_ready=1, out_pc=0, out_inst=NOP_INST, count=0.
  - Reset mid-operation drops all entries. No partial state survives.
- Storage:
  - Circular array of DEPTH entries of {pc, inst}.
  - wr_ptr and rd_ptr are log2(DEPTH) bits and wrap modulo DEPTH naturally.
  - count is kept separately; full is count==DEPTH, empty is count==0.
- Handshake signals:
  - enq = in_valid & in_ready & ~flush.
  - deq = out_valid & out_ready.
  - in_ready = (count != DEPTH). It does not depend on out_ready, so there is no combinational path from decode back to fetch. When full, a same-cycle dequeue does not open a slot until the next cycle.
  - out_valid = (count != 0) & ~flush. The flush term is combinational so decode never consumes a stale instruction in the redirect cycle.
- Output data:
  - out_pc/out_inst = mem[rd_ptr] when count != 0.
  - Otherwise 0 / NOP_INST.
- Latency:
  - An entry written at edge N is visible on out_* in the cycle after edge N; enqueue-to-visible is 1 cycle.
  - There is no same-cycle bypass from in_* to out_*.
- Per-edge update, in priority order:
  1. flush=1: wr_ptr, rd_ptr and count go to 0; enq and deq are both suppressed.
  2. enq & deq: write at wr_ptr, both pointers advance, count unchanged.
  3. enq only: write, wr_ptr+1, count+1.
  4. deq only: rd_ptr+1, count-1.
  5. Neither: hold.
- Stable input: while in_valid=1 and in_ready=0, fetch holds in_pc/in_inst stable; the buffer assumes this and does not latch early.
- Flush with in_valid: the incoming instruction is discarded. Fetch presents the redirect target on a later cycle.
- Overflow/underflow: impossible by construction. Write a simulation assertion that count never exceeds DEPTH and never goes negative.
- Control structure: no FSM beyond the pointer/count datapath. The FIFO state is fully described by count (EMPTY / PARTIAL / FULL).

Decomposition:
- Shared package constant: NOP_INST, reused by decode for bubble insertion.
- Shared package typedef: fetch-packet struct {pc[PC_W-1:0], inst[INST_W-1:0]}.
- Natural sub-module: if_id_fifo_mem, a DEPTH x (PC_W+INST_W) register array with one write port and one asynchronous read port, no reset on data.
- Pointer/count/flush control stays in if_id_buf.

Test Plan:
- Reset then idle: out_valid=0, in_ready=1, count=0, out_inst=32'h00000013, out_pc=0.
- Single enqueue {pc=64'h80000000, inst=32'h00000297} with out_ready=0: next cycle out_valid=1, out_pc=64'h80000000, count=1; holds indefinitely.
- Fill to full with pc 0x80000000 and 0x80000004 while out_ready=0: count=2, in_ready=0. In the next cycle set out_ready=1 and in_valid=1 with pc 0x80000008. Head dequeues, 0x80000008 is not accepted that cycle, and it is accepted on the following cycle. Order out is 0x80000000, 0x80000004, 0x80000008.
- Streaming: in_valid=out_ready=1 for 10 cycles with PC incrementing by 4. After 1-cycle fill, count stays 1 and every PC appears exactly once in order, including across pointer wrap.
- Flush with count=2 and in_valid=1 (pc 0x80000010): out_valid=0 that cycle; next cycle count=0 and 0x80000010 is never output. Then enqueue 0x80000100, which is the next out_pc.
- Asynchronous reset pulse mid-cycle with count=2: outputs return to reset values before the next clk edge; the entries never reappear after reset release.
